pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the RV32I fetch/decode boundary. Owns the PC register.
//  Accepts one instruction per valid/ready handshake and decodes JAL, JALR and all six conditional
//  branches (BEQ/BNE/BLT/BGE/BLTU/BGEU); every other opcode falls through to pc+4.
//  Resolves the next PC, raises a one-cycle redirect to fetch, and traps misaligned control-transfer targets.
// PARAMETERS
//  XLEN      32            datapath / PC width
//  RESET_PC  32'h0000_0000 PC value after reset
//  TRAP_VEC  32'h0000_0100 PC loaded after a misalignment trap is acknowledged
//  CNT_W     32            width of each performance counter (used only with PC_PERF_CNT_EN)
// PORTS
//  clk            in  1     clock; all state updates on the rising edge
//  rst_n          in  1     synchronous reset, active low
//  inst_valid     in  1     fetch presents inst_encoding for the current pc
//  inst_ready     out 1     sequencer accepts; handshake = inst_valid & inst_ready
//  inst_encoding  in  32    instruction word
//  rs1_data       in  XLEN  rs1 operand (register-file read)
//  rs2_data       in  XLEN  rs2 operand
//  stall          in  1     hazard hold; forces inst_ready low
//  pc             out XLEN  registered PC of the instruction expected next
//  next_pc_sel    out 2     combinational select for the presented instruction (`NEXT_PC_* from decode.vh)
//  redirect       out 1     one-cycle pulse: fetch flushes and restarts at redirect_pc
//  redirect_pc    out XLEN  valid while redirect=1
//  trap_req       out 1     misaligned-target trap pending; held until trap_ack
//  trap_pc        out XLEN  PC of the faulting instruction
//  trap_ack       in  1     trap acknowledge
//  instret_cnt    out CNT_W accepted-instruction count
//  taken_cnt      out CNT_W taken-transfer count
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=BOOT, pc=RESET_PC, redirect=0, redirect_pc=0, trap_req=0, trap_pc=0,
//    counters=0. Reset mid-operation aborts any FLUSH or TRAP state with no residual pulse.
//  - States:
//    - BOOT: inst_ready=0, one cycle, then RUN.
//    - RUN: inst_ready = ~stall.
//    - FLUSH: inst_ready=0 and redirect=1 for exactly one cycle, then RUN; an instruction presented during
//      FLUSH is dropped.
//    - TRAP: inst_ready=0, trap_req=1; on trap_ack, pc=TRAP_VEC, redirect_pc=TRAP_VEC, then FLUSH.
//  - Handshake in RUN: target is computed from the presented instruction and the current pc.
//    - JAL:    target = pc + J-immediate (sign-extended).
//    - JALR:   target = (rs1_data + I-immediate) & ~1.
//    - Branch: target = pc + B-immediate; compares are signed for BLT/BGE, unsigned for BLTU/BGEU.
//  - Not-taken / fall-through: pc <= pc+4, stay in RUN. Back-to-back handshakes sustain one per cycle.
//  - Taken with target[1]=0: pc <= target, redirect_pc <= target, go to FLUSH. Redirect appears in the cycle
//    after the handshake.
//  - Taken with target[1]=1: pc unchanged, trap_pc <= pc, go to TRAP. No misalignment check is made on
//    not-taken branches.
//  - All address arithmetic is modulo 2^XLEN: pc+4 from 0xFFFF_FFFC wraps to 0x0.
//  - stall=1 with inst_valid=1: no handshake; pc and all state are held.
//  - trap_ack outside TRAP is ignored. trap_ack asserted in the same cycle trap_req rises is honoured on the
//    next edge, so the TRAP dwell is at least 1 cycle.
//  - next_pc_sel is combinational: JAL=01, JALR=10, branch=11, otherwise 00.
// CONFIGURATION
//  PC_PERF_CNT_EN defined:
//    - instret_cnt +1 per handshake; taken_cnt +1 per taken, non-trapping transfer.
//    - Both counters saturate at all-ones; both are cleared by reset.
//  PC_PERF_CNT_EN undefined: instret_cnt and taken_cnt are tied to 0; no counter flops are instantiated.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles, then 1 -> pc=0x0, inst_ready=0 in the first cycle, inst_ready=1 in the second.
//  2. ADDI x3 back-to-back, inst_valid=1 -> pc 0x0,0x4,0x8,0xC on consecutive cycles; redirect stays 0.
//  3. JAL +0x100 at pc 0x8 -> next_pc_sel=01; next cycle redirect=1, redirect_pc=0x108, inst_ready=0;
//     following cycle pc=0x108, RUN.
//  4. BNE rs1=rs2=5 -> pc+4, no redirect. BLTU rs1=1, rs2=0xFFFF_FFFF, imm=-8 at pc 0x20 -> redirect_pc=0x18.
//  5. JALR rs1=0x203, imm=0 at pc 0x40 -> trap_req=1, trap_pc=0x40, held 3 cycles; trap_ack -> redirect_pc=0x100,
//     pc=0x100.
//  6. stall=1 for 4 cycles with inst_valid=1 -> pc held, counters frozen. With PC_PERF_CNT_EN after scenarios
//     2-3: instret_cnt=4, taken_cnt=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer at the RV32I fetch/decode boundary. Owns the PC
//   register and accepts one instruction per valid/ready handshake. It decodes
//   JAL, JALR and the six conditional branches; every other opcode falls
//   through to pc+4. Taken transfers raise a one-cycle redirect to fetch.
//   Targets with bit 1 set raise a trap that is held until acknowledged.
//
//   Optional feature: define PC_PERF_CNT_EN to build saturating retired and
//   taken-transfer counters. Without it both counter outputs are tied to 0 and
//   no counter flops exist.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   inst_valid/_ready  instruction handshake (ready low while stalled or not RUN)
//   inst_encoding   instruction word for the current pc
//   rs1_data/rs2_data  register operands for JALR and branch compares
//   stall           hazard hold, forces inst_ready low
//   pc              registered PC of the instruction expected next
//   next_pc_sel     combinational decode: 00 seq, 01 JAL, 10 JALR, 11 branch
//   redirect/_pc    one-cycle flush pulse and restart address
//   trap_req/_pc/_ack  misaligned-target trap, faulting PC, acknowledge
//   instret_cnt     accepted-instruction count
//   taken_cnt       taken, non-trapping transfer count
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst_encoding,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             stall,
  output logic [XLEN-1:0]  pc,
  output logic [1:0]       next_pc_sel,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             trap_req,
  output logic [XLEN-1:0]  trap_pc,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] NEXT_PC_SEQ  = 2'b00;
  localparam logic [1:0] NEXT_PC_JAL  = 2'b01;
  localparam logic [1:0] NEXT_PC_JALR = 2'b10;
  localparam logic [1:0] NEXT_PC_BR   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH,
    ST_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  // ---------------------------------------------------------------------------
  // Decode and target computation for the presented instruction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, jalr_sum;
  logic            br_eq, br_lt_s, br_lt_u, br_taken;
  logic            xfer_taken;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            handshake;

  assign opcode = inst_encoding[6:0];
  assign funct3 = inst_encoding[14:12];

  assign imm_i = {{(XLEN-12){inst_encoding[31]}}, inst_encoding[31:20]};
  assign imm_b = {{(XLEN-13){inst_encoding[31]}}, inst_encoding[31], inst_encoding[7],
                  inst_encoding[30:25], inst_encoding[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst_encoding[31]}}, inst_encoding[31], inst_encoding[19:12],
                  inst_encoding[20], inst_encoding[30:21], 1'b0};

  assign jalr_sum = rs1_data + imm_i;

  assign br_eq   = (rs1_data == rs2_data);
  assign br_lt_s = ($signed(rs1_data) < $signed(rs2_data));
  assign br_lt_u = (rs1_data < rs2_data);

  always_comb begin
    case (funct3)
      3'b000:  br_taken = br_eq;     // BEQ
      3'b001:  br_taken = !br_eq;    // BNE
      3'b100:  br_taken = br_lt_s;   // BLT
      3'b101:  br_taken = !br_lt_s;  // BGE
      3'b110:  br_taken = br_lt_u;   // BLTU
      3'b111:  br_taken = !br_lt_u;  // BGEU
      default: br_taken = 1'b0;      // reserved funct3 never transfers
    endcase
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    next_pc_sel = NEXT_PC_SEQ;
    xfer_taken  = 1'b0;
    target      = pc_q + XLEN'(4);
    case (opcode)
      OPC_JAL: begin
        next_pc_sel = NEXT_PC_JAL;
        xfer_taken  = 1'b1;
        target      = pc_q + imm_j;
      end
      OPC_JALR: begin
        next_pc_sel = NEXT_PC_JALR;
        xfer_taken  = 1'b1;
        target      = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        next_pc_sel = NEXT_PC_BR;
        xfer_taken  = br_taken;
        target      = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  // Bit 0 is always clear here (JALR masks it, J/B immediates are even), so
  // only bit 1 can make a target misaligned.
  assign misaligned = target[1];

  assign inst_ready = (state_q == ST_RUN) && !stall;
  assign handshake  = inst_valid && inst_ready;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    trap_pc_d     = trap_pc_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN: begin
        if (handshake) begin
          if (!xfer_taken) begin
            pc_d = pc_q + XLEN'(4);
          end else if (misaligned) begin
            trap_pc_d = pc_q;
            state_d   = ST_TRAP;
          end else begin
            pc_d          = target;
            redirect_pc_d = target;
            state_d       = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_TRAP: begin
        if (trap_ack) begin
          pc_d          = TRAP_VEC;
          redirect_pc_d = TRAP_VEC;
          state_d       = ST_FLUSH;
        end
      end
      default:  state_d = ST_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
      trap_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      trap_pc_q     <= trap_pc_d;
    end
  end

  assign pc          = pc_q;
  assign redirect    = (state_q == ST_FLUSH);
  assign redirect_pc = redirect_pc_q;
  assign trap_req    = (state_q == ST_TRAP);
  assign trap_pc     = trap_pc_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, taken_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
      taken_q   <= '0;
    end else begin
      // Both counters stick at all-ones instead of wrapping.
      if (handshake && !(&instret_q)) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (handshake && xfer_taken && !misaligned && !(&taken_q)) begin
        taken_q <= taken_q + CNT_W'(1);
      end
    end
  end

  assign instret_cnt = instret_q;
  assign taken_cnt   = taken_q;
`else
  assign instret_cnt = '0;
  assign taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer. Stimulus pushes hand-computed expectations
//   into scoreboard queues (handshakes, redirects, traps); a negedge monitor
//   pops and compares whenever the DUT presents one of those events. Direct
//   checks cover reset, trap dwell, stall hold and the counters.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int CNT_W = 32;
`ifdef PC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Hand-assembled encodings
  localparam logic [31:0] ADDI_X3 = 32'h0010_0193;  // addi x3, x0, 1
  localparam logic [31:0] JAL_100 = 32'h1000_00EF;  // jal  x1, +0x100
  localparam logic [31:0] JALR_X1 = 32'h0000_8067;  // jalr x0, 0(x1)
  localparam logic [31:0] BNE_8   = 32'h0020_9463;  // bne  x1, x2, +8
  localparam logic [31:0] BLTU_M8 = 32'hFE20_ECE3;  // bltu x1, x2, -8
  localparam logic [31:0] BLT_8   = 32'h0020_C463;  // blt  x1, x2, +8

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_valid = 1'b0;
  logic             inst_ready;
  logic [31:0]      inst_encoding = '0;
  logic [31:0]      rs1_data = '0;
  logic [31:0]      rs2_data = '0;
  logic             stall = 1'b0;
  logic [31:0]      pc;
  logic [1:0]       next_pc_sel;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             trap_req;
  logic [31:0]      trap_pc;
  logic             trap_ack = 1'b0;
  logic [CNT_W-1:0] instret_cnt;
  logic [CNT_W-1:0] taken_cnt;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_encoding (inst_encoding),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .stall         (stall),
    .pc            (pc),
    .next_pc_sel   (next_pc_sel),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .trap_req      (trap_req),
    .trap_pc       (trap_pc),
    .trap_ack      (trap_ack),
    .instret_cnt   (instret_cnt),
    .taken_cnt     (taken_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  sel;
  } hs_exp_t;

  hs_exp_t     hs_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] trap_q[$];
  bit          mon_en    = 1'b0;
  bit          trap_seen = 1'b0;
  hs_exp_t     hs_e;
  logic [31:0] word_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: actual=0x%0h expected=none", name, act);
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    return PERF ? CNT_W'(n) : '0;
  endfunction

  // Present one instruction and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] enc, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] exp_pc, input logic [1:0] exp_sel);
    bit done = 1'b0;
    hs_q.push_back({exp_pc, exp_sel});
    inst_encoding = enc;
    rs1_data      = r1;
    rs2_data      = r2;
    inst_valid    = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (inst_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    inst_valid = 1'b0;
    if (!done) fail_now("handshake_timeout", {32'h0, exp_pc});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (inst_valid && inst_ready) begin
        if (hs_q.size() == 0) begin
          fail_now("unexpected_handshake", {32'h0, pc});
        end else begin
          hs_e = hs_q.pop_front();
          check("hs_pc", {32'h0, pc}, {32'h0, hs_e.pc});
          check("hs_sel", {62'h0, next_pc_sel}, {62'h0, hs_e.sel});
        end
      end
      if (redirect) begin
        if (rd_q.size() == 0) begin
          fail_now("unexpected_redirect", {32'h0, redirect_pc});
        end else begin
          word_e = rd_q.pop_front();
          check("redirect_pc", {32'h0, redirect_pc}, {32'h0, word_e});
          check("flush_ready", {63'h0, inst_ready}, 64'h0);
        end
      end
      if (trap_req && !trap_seen) begin
        trap_seen = 1'b1;
        if (trap_q.size() == 0) begin
          fail_now("unexpected_trap", {32'h0, trap_pc});
        end else begin
          word_e = trap_q.pop_front();
          check("trap_pc", {32'h0, trap_pc}, {32'h0, word_e});
        end
      end else if (!trap_req) begin
        trap_seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges, then the BOOT cycle.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pc", {32'h0, pc}, 64'h0);
    check("rst_ready", {63'h0, inst_ready}, 64'h0);
    check("rst_redirect", {63'h0, redirect}, 64'h0);
    check("rst_redirect_pc", {32'h0, redirect_pc}, 64'h0);
    check("rst_trap_req", {63'h0, trap_req}, 64'h0);
    check("rst_trap_pc", {32'h0, trap_pc}, 64'h0);
    check("rst_instret", {32'h0, instret_cnt}, 64'h0);
    check("rst_taken", {32'h0, taken_cnt}, 64'h0);
    mon_en = 1'b1;
    @(posedge clk);
    #1 check("run_ready", {63'h0, inst_ready}, 64'h1);

    // Sequential flow, then JAL +0x100 from 0x8.
    send(ADDI_X3, 32'h0, 32'h0, 32'h0000_0000, 2'b00);
    send(ADDI_X3, 32'h0, 32'h0, 32'h0000_0004, 2'b00);
    rd_q.push_back(32'h0000_0108);
    send(JAL_100, 32'h0, 32'h0, 32'h0000_0008, 2'b01);
    send(ADDI_X3, 32'h0, 32'h0, 32'h0000_0108, 2'b00);
    check("pc_after_jal", {32'h0, pc}, 64'h10C);
    check("instret_4", {32'h0, instret_cnt}, {32'h0, exp_cnt(4)});
    check("taken_1", {32'h0, taken_cnt}, {32'h0, exp_cnt(1)});

    // Branches: BNE equal falls through; BLTU unsigned taken; BLT signed not.
    send(BNE_8, 32'd5, 32'd5, 32'h0000_010C, 2'b11);
    rd_q.push_back(32'h0000_0020);
    send(JALR_X1, 32'h0000_0020, 32'h0, 32'h0000_0110, 2'b10);
    rd_q.push_back(32'h0000_0018);
    send(BLTU_M8, 32'h1, 32'hFFFF_FFFF, 32'h0000_0020, 2'b11);
    send(BLT_8, 32'h1, 32'hFFFF_FFFF, 32'h0000_0018, 2'b11);
    check("pc_after_blt", {32'h0, pc}, 64'h1C);

    // trap_ack outside TRAP is ignored.
    trap_ack = 1'b1;
    @(posedge clk);
    #1 trap_ack = 1'b0;
    check("stray_ack_pc", {32'h0, pc}, 64'h1C);
    check("stray_ack_trap", {63'h0, trap_req}, 64'h0);

    // Misaligned JALR target 0x202 from pc 0x40.
    rd_q.push_back(32'h0000_0040);
    send(JALR_X1, 32'h0000_0040, 32'h0, 32'h0000_001C, 2'b10);
    trap_q.push_back(32'h0000_0040);
    send(JALR_X1, 32'h0000_0203, 32'h0, 32'h0000_0040, 2'b10);
    check("instret_10", {32'h0, instret_cnt}, {32'h0, exp_cnt(10)});
    check("taken_4", {32'h0, taken_cnt}, {32'h0, exp_cnt(4)});
    for (int i = 0; i < 3; i++) begin
      check("trap_held", {63'h0, trap_req}, 64'h1);
      check("trap_pc_hold", {32'h0, pc}, 64'h40);
      check("trap_ready", {63'h0, inst_ready}, 64'h0);
      @(posedge clk);
      #1;
    end
    rd_q.push_back(32'h0000_0100);
    trap_ack = 1'b1;
    @(posedge clk);
    #1 trap_ack = 1'b0;
    check("ack_pc", {32'h0, pc}, 64'h100);
    check("ack_redirect", {63'h0, redirect}, 64'h1);
    @(posedge clk);
    #1;
    check("post_flush_redirect", {63'h0, redirect}, 64'h0);
    check("post_flush_trap", {63'h0, trap_req}, 64'h0);

    // Stall with a valid instruction: nothing moves.
    stall         = 1'b1;
    inst_encoding = ADDI_X3;
    inst_valid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("stall_pc", {32'h0, pc}, 64'h100);
    end
    check("stall_instret", {32'h0, instret_cnt}, {32'h0, exp_cnt(10)});
    check("stall_taken", {32'h0, taken_cnt}, {32'h0, exp_cnt(4)});
    inst_valid = 1'b0;
    stall      = 1'b0;

    // PC wrap from 0xFFFF_FFFC.
    send(ADDI_X3, 32'h0, 32'h0, 32'h0000_0100, 2'b00);
    rd_q.push_back(32'hFFFF_FFFC);
    send(JALR_X1, 32'hFFFF_FFFC, 32'h0, 32'h0000_0104, 2'b10);
    send(ADDI_X3, 32'h0, 32'h0, 32'hFFFF_FFFC, 2'b00);
    check("pc_wrap", {32'h0, pc}, 64'h0);
    check("instret_13", {32'h0, instret_cnt}, {32'h0, exp_cnt(13)});
    check("taken_5", {32'h0, taken_cnt}, {32'h0, exp_cnt(5)});

    // Reset during FLUSH leaves no residual redirect.
    rd_q.push_back(32'h0000_0100);
    send(JAL_100, 32'h0, 32'h0, 32'h0000_0000, 2'b01);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_rst_redirect", {63'h0, redirect}, 64'h0);
    check("mid_rst_pc", {32'h0, pc}, 64'h0);
    check("mid_rst_redirect_pc", {32'h0, redirect_pc}, 64'h0);
    check("mid_rst_ready", {63'h0, inst_ready}, 64'h0);
    check("mid_rst_instret", {32'h0, instret_cnt}, 64'h0);
    check("mid_rst_taken", {32'h0, taken_cnt}, 64'h0);
    @(posedge clk);
    #1;
    check("mid_rst_run_ready", {63'h0, inst_ready}, 64'h1);
    check("mid_rst_no_pulse", {63'h0, redirect}, 64'h0);

    check("hs_q_empty", 64'(hs_q.size()), 64'h0);
    check("rd_q_empty", 64'(rd_q.size()), 64'h0);
    check("trap_q_empty", 64'(trap_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
